// File: rtl/xor_key_sequencer.sv
// xor_key_sequencer: loads a key into an external 2**W x B register file, then
// XORs a byte stream against that key with a cycling index (encrypt == decrypt).
module xor_key_sequencer #(
    parameter int B = 8,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         key_start,
    input  logic         key_valid,
    input  logic [B-1:0] key_data,
    input  logic         key_last,
    output logic         key_ready,
    input  logic         in_valid,
    input  logic [B-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [B-1:0] out_data,
    input  logic         out_ready,
    output logic [W:0]   key_len,
    output logic         busy,
    output logic         rf_we,
    output logic [W-1:0] rf_wa,
    output logic [B-1:0] rf_wd,
    output logic [W-1:0] rf_ra,
    input  logic [B-1:0] rf_rd
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [W-1:0] PTR_ONE = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W:0]   LEN_ONE = {{W{1'b0}}, 1'b1};

    logic [1:0]   r_state;
    logic [W-1:0] r_wr_ptr;
    logic [W-1:0] r_rd_ptr;
    logic [W:0]   r_key_len;
    logic         r_out_valid;
    logic [B-1:0] r_out_data;

    logic w_out_free;
    logic w_key_ready;
    logic w_in_ready;
    logic w_key_acc;
    logic w_in_acc;
    logic w_key_done;
    logic w_rd_wrap;

    always_comb begin
        w_out_free  = !r_out_valid || out_ready;
        w_key_ready = (r_state == S_LOAD) && !key_start;
        w_in_ready  = (r_state == S_RUN) && !key_start && w_out_free;
        w_key_acc   = key_valid && w_key_ready;
        w_in_acc    = in_valid && w_in_ready;
        w_key_done  = key_last || (r_wr_ptr == '1);
        w_rd_wrap   = ({1'b0, r_rd_ptr} == (r_key_len - LEN_ONE));
    end

    assign key_ready = w_key_ready;
    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign key_len   = r_key_len;
    assign busy      = (r_state == S_LOAD) || (r_state == S_DRAIN);
    assign rf_we     = w_key_acc;
    assign rf_wa     = r_wr_ptr;
    // Forced to zero in IDLE so every combinational output is quiet out of reset.
    assign rf_wd     = (r_state == S_IDLE) ? '0 : key_data;
    assign rf_ra     = r_rd_ptr;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_key_len   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (key_start) begin
                        r_state  <= S_LOAD;
                        r_wr_ptr <= '0;
                    end
                end
                S_LOAD: begin
                    if (key_start) begin
                        r_wr_ptr <= '0;
                    end else if (w_key_acc) begin
                        r_wr_ptr <= r_wr_ptr + PTR_ONE;
                        if (w_key_done) begin
                            r_key_len <= {1'b0, r_wr_ptr} + LEN_ONE;
                            r_rd_ptr  <= '0;
                            r_state   <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (key_start) begin
                        // A pending result that cannot leave this cycle is held in DRAIN.
                        if (w_out_free) begin
                            r_state  <= S_LOAD;
                            r_wr_ptr <= '0;
                            if (out_ready) begin
                                r_out_valid <= 1'b0;
                            end
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end else if (w_in_acc) begin
                        r_out_data  <= in_data ^ rf_rd;
                        r_out_valid <= 1'b1;
                        r_rd_ptr    <= w_rd_wrap ? '0 : (r_rd_ptr + PTR_ONE);
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_LOAD;
                        r_wr_ptr    <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
